// File: rtl/time_pkg.sv
// Shared definitions for the time-base controller: sequencer states and default widths.
package time_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/tb_channel.sv
// One time-base channel: shadow/active divide config, period counter and tick/clock decode.
module tb_channel
  import time_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             arm_i,
  input  logic             wr_i,
  input  logic             cfg_en_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic             pend_o
);

  logic             en_q, en_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             sh_en_q, sh_en_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             live;
  logic [CNT_W-1:0] last_cnt;
  logic             at_wrap;
  logic             apply;

  assign live     = en_q && (div_q != '0);
  assign last_cnt = (div_q != '0) ? (div_q - CNT_W'(1)) : '0;
  assign at_wrap  = live && (cnt_q == last_cnt);

  always_comb begin
    en_d     = en_q;
    div_d    = div_q;
    sh_en_d  = sh_en_q;
    sh_div_d = sh_div_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    apply    = 1'b0;

    // Shadow config only moves to active at a period boundary so no runt period appears.
    if (arm_i) begin
      apply = pend_q;
      cnt_d = '0;
    end else if (run_i) begin
      if (!live) begin
        apply = pend_q;
        cnt_d = '0;
      end else if (at_wrap) begin
        apply = pend_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    if (apply) begin
      en_d   = sh_en_q;
      div_d  = sh_div_q;
      pend_d = 1'b0;
    end

    if (wr_i) begin
      sh_en_d  = cfg_en_i;
      sh_div_d = cfg_div_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= 1'b0;
      div_q    <= '0;
      sh_en_q  <= 1'b0;
      sh_div_q <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      en_q     <= en_d;
      div_q    <= div_d;
      sh_en_q  <= sh_en_d;
      sh_div_q <= sh_div_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tick_o    = run_i && at_wrap;
  assign clk_out_o = run_i && live && (cnt_q < (div_q >> 1));
  assign pend_o    = pend_q;

endmodule

// File: rtl/time_base_ctrl.sv
// Multi-channel time-base controller: IDLE/ARM/RUN sequencer, config handshake and channel array.
module time_base_ctrl
  import time_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK_IN,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  input  logic              SYNC,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic              CFG_EN,
  input  logic [CNT_W-1:0]  CFG_DIV,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK,
  output logic              RUNNING,
  output logic [NUM_CH-1:0] PENDING
);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] pend_vec;
  logic [NUM_CH-1:0] wr_vec;
  logic              pend_sel;
  logic              run, arm;

  always_comb begin
    state_d = state_q;
    if (STOP) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (START) state_d = ST_ARM;
        ST_ARM:  state_d = ST_RUN;
        ST_RUN:  if (SYNC) state_d = ST_ARM;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign run     = (state_q == ST_RUN);
  assign arm     = (state_q == ST_ARM);
  assign RUNNING = run;

  // An out-of-range channel never matches, so it reads as not pending and is always ready.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CFG_CH == CH_W'(i)) pend_sel = pend_vec[i];
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE: CFG_READY = 1'b1;
      ST_RUN:  CFG_READY = ~pend_sel;
      default: CFG_READY = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign wr_vec[gi] = CFG_VALID && CFG_READY && (CFG_CH == CH_W'(gi));

    tb_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i     (CLK_IN),
      .rst_i     (RST),
      .run_i     (run),
      .arm_i     (arm),
      .wr_i      (wr_vec[gi]),
      .cfg_en_i  (CFG_EN),
      .cfg_div_i (CFG_DIV),
      .tick_o    (TICK[gi]),
      .clk_out_o (CLK_OUT[gi]),
      .pend_o    (pend_vec[gi])
    );
  end

  assign PENDING = pend_vec;

endmodule

// File: doc/time_base_ctrl.md
# time_base_ctrl

- Multi-channel time-base controller for the timing subsystem.
- Owns `NUM_CH` programmable clock-divider channels and sequences them through idle, arm and run phases.
- Accepts per-channel divide configuration over a valid/ready port and applies new divide values glitch-free at period boundaries.
- Per channel, produces a 50%-style divided clock level and a one-cycle period tick, phase-aligned across channels on start or resync.

## Interface
Parameters:
- `NUM_CH`, 4: number of divider channels (1..16).
- `CNT_W`, 16: counter and divide-value width.
- `CH_W`, `$clog2(NUM_CH)` (min 1): channel index width; derived, not overridden.

Ports:
- `CLK_IN`  in  1  single clock; all logic on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  level-sampled; IDLE→ARM.
- `STOP`  in  1  level-sampled; any state→IDLE.
- `SYNC`  in  1  level-sampled; RUN→ARM (realign all channels).
- `CFG_VALID`  in  1  config request.
- `CFG_READY`  out  1  config accept; transfer on `CFG_VALID & CFG_READY`.
- `CFG_CH`  in  CH_W  target channel; values ≥ `NUM_CH` are accepted and discarded.
- `CFG_EN`  in  1  channel enable.
- `CFG_DIV`  in  CNT_W  divide ratio; 0 means disabled.
- `CLK_OUT`  out  NUM_CH  per-channel divided clock level.
- `TICK`  out  NUM_CH  per-channel one-cycle pulse on the last count of each period.
- `RUNNING`  out  1  high in RUN.
- `PENDING`  out  NUM_CH  shadow config waiting to be applied.

## Operation
FSM states: IDLE, ARM, RUN. Reset state is IDLE.

State transitions:
- IDLE→ARM on `START`.
- ARM→RUN unconditionally after one cycle.
- RUN→ARM on `SYNC`.
- Any state→IDLE on `STOP`.
- `STOP` has priority over `START` and `SYNC`. `START` in RUN/ARM is ignored.

Per-channel registers:
- Shadow: `sh_en`, `sh_div`.
- Active: `en`, `div`.
- Counter: `cnt`.
- `pend` flag.

Config writes:
- IDLE: always ready. Write lands in the shadow and sets `pend`; a later write overwrites it.
- ARM: `CFG_READY`=0.
- RUN: `CFG_READY` = `~pend[CFG_CH]` (0 for an out-of-range `CFG_CH` is not applied; out-of-range is always ready). A write sets `pend`.

ARM behaviour:
- Every channel with `pend` copies shadow to active and clears `pend`.
- All `cnt` are set to 0.

RUN behaviour, per channel live (`en` && `div`≠0):
- If `cnt == div-1`: `cnt`←0. If `pend`, copy shadow to active and clear `pend` at that same edge.
- Otherwise `cnt`←`cnt+1`.

RUN behaviour, non-live channel:
- `cnt` is held at 0.
- A pending shadow is applied on the next cycle.

Outputs (combinational from registers):
- `TICK[i]` = RUN && live && `cnt == div-1`.
- `CLK_OUT[i]` = RUN && live && `cnt < (div>>1)`.
- `div`=1 gives `TICK` every cycle and `CLK_OUT` constant 0.
- Odd `div`: high for `div>>1` cycles, low for the remainder.

IDLE outputs: `cnt`=0 and all outputs 0; the active config is retained.

`STOP` then `START`:
- The active config is retained.
- Pending shadows are applied in ARM.

## Timing
- Reset values: state IDLE; `cnt`, `div`, `en`, shadows, `pend` all 0. Outputs: `TICK`=0, `CLK_OUT`=0, `RUNNING`=0, `PENDING`=0, `CFG_READY`=1.
- `START` sampled at edge E: ARM during cycle E+1, RUN from cycle E+2 with `cnt`=0.
- First `TICK` is in RUN cycle `div`, i.e. `div-1` cycles after entering RUN.
- Config accepted in the same cycle as a channel's wrap: not applied at that wrap, but at the following one.
- New divide takes effect starting at count 0; no truncated or extended period, no runt `CLK_OUT` pulse.
- `SYNC`: every channel restarts at count 0, two cycles after `SYNC` is sampled. Ticks are suppressed during ARM.
- `RST` mid-RUN: next cycle is full reset state; pending config is lost.
- Arithmetic: `cnt`, `div` are `CNT_W` unsigned; `div-1` is computed only when `div`≠0; no overflow possible.

## Structure
- Shared package `time_pkg`: FSM state enum (IDLE/ARM/RUN) and the `CNT_W` default constant.
- Sub-module `tb_channel`: one channel, containing the shadow/active registers, `pend`, counter, `TICK`/`CLK_OUT` decode.
  - Inputs: `run`, `arm`, `wr`, `cfg_en`, `cfg_div`.
  - Generated `NUM_CH` times.
- Top holds the FSM, `CFG_READY` mux and channel write-enable decode.

## Test plan
- Reset, then channel 0 programmed `EN`=1, `DIV`=4 in IDLE, then `START`: RUN 2 cycles later; `CLK_OUT[0]` pattern 1,1,0,0 repeating; `TICK[0]` at each count 3; `PENDING` clears in ARM.
- RUN on `DIV`=5, write `DIV`=3 mid-period: `CFG_READY` drops for ch0; the current 5-cycle period completes; then 3-cycle periods; `CLK_OUT` pattern 1,1,0,0,0 then 1,0,0.
- Channels 0/1/2 programmed `DIV`=2/3/6, `SYNC` asserted at an arbitrary RUN cycle: all ticks stop for 2 cycles; all counters restart at 0; all three `TICK` coincide every 6 cycles afterward.
- `STOP` and `SYNC` in the same cycle: next state IDLE; all outputs 0; later `START` resumes with the retained divides.
- `DIV`=0, `DIV`=1 and `EN`=0 on three channels: outputs always 0; constant `TICK`=1 with `CLK_OUT`=0; outputs always 0, respectively.
- `RST` during RUN with a pending write: all outputs and `PENDING` are 0 next cycle; `CFG_READY`=1.
